// File: rtl/mul_pkg.sv
// Shared types and default widths for the multiplier front end (operand feeder, lane skew).
package mul_pkg;

    localparam int DEF_BUS_WIDTH  = 64;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LANES      = 4;
    localparam int DEF_ELEM_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 11;

    typedef enum logic {
        ELEM_NARROW = 1'b0,
        ELEM_NATIVE = 1'b1
    } elem_mode_e;

    typedef enum logic {
        FD_EMPTY = 1'b0,
        FD_HOLD  = 1'b1
    } fd_state_e;

    // Counter width that stays at least one bit wide for single-beat configurations.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lane_skew.sv
// Triangular skew: lane j is delayed by j advances, so lane 0 passes straight through.
module lane_skew
    import mul_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        adv,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic [LANES*DATA_WIDTH-1:0] out_data
);

    assign out_data[DATA_WIDTH-1:0] = in_data[DATA_WIDTH-1:0];

    for (genvar j = 1; j < LANES; j++) begin : g_lane
        logic [DATA_WIDTH-1:0] sr [j];

        // NOTE: these stages are visible on out_skew, so they are cleared on reset like any control flop.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < j; k++) sr[k] <= '0;
            end else if (clr) begin
                for (int k = 0; k < j; k++) sr[k] <= '0;
            end else if (adv) begin
                sr[0] <= in_data[j*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
            end
        end

        assign out_data[j*DATA_WIDTH +: DATA_WIDTH] = sr[j-1];
    end

endmodule

// File: rtl/operand_feeder.sv
// operand_feeder: one-word holding buffer that unpacks BRAM words into LANES-wide beats.
// Define OPERAND_FEEDER_SKEW_EN to add the skewed out_skew port for the systolic front end.
module operand_feeder
    import mul_pkg::*;
#(
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        elem_mode,
    input  logic                        sign_ext,
    input  logic [CNT_WIDTH-1:0]        cfg_words,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BUS_WIDTH-1:0]        in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        out_tile_last
`ifdef OPERAND_FEEDER_SKEW_EN
    ,
    output logic [LANES*DATA_WIDTH-1:0] out_skew
`endif
);

    localparam int BEAT_BITS = ELEM_WIDTH * LANES;
    localparam int NB_NARROW = BUS_WIDTH / BEAT_BITS;
    localparam int BEAT_W    = clog2_min1(NB_NARROW);

    fd_state_e                   state_q, state_d;
    logic [BUS_WIDTH-1:0]        word_q;
    elem_mode_e                  mode_q;
    logic                        sext_q;
    logic [BEAT_W-1:0]           beat_q;
    logic [CNT_WIDTH-1:0]        wcnt_q;
    logic                        last_beat, accept, out_fire, tile_end;
    logic [BUS_WIDTH-1:0]        shifted;
    logic [ELEM_WIDTH-1:0]       elem;
    logic [LANES*DATA_WIDTH-1:0] lanes;

    assign last_beat     = (mode_q == ELEM_NATIVE) || (beat_q == BEAT_W'(NB_NARROW - 1));
    assign out_last      = out_valid && last_beat;
    assign tile_end      = (cfg_words != '0) && (wcnt_q == cfg_words - 1'b1);
    assign out_tile_last = out_last && tile_end;
    assign out_fire      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FD_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        unique case (state_q)
            FD_EMPTY: in_ready = 1'b1;
            FD_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready && last_beat;
            end
            default: state_d = FD_EMPTY;
        endcase
        accept = in_valid && in_ready && !flush;
        if (flush)                                              state_d = FD_EMPTY;
        else if (accept)                                        state_d = FD_HOLD;
        else if (state_q == FD_HOLD && out_ready && last_beat)  state_d = FD_EMPTY;
    end

    // Mode and sign are captured with the word so later input changes cannot alter a held word.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use <= so every flop samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            word_q <= '0;
            mode_q <= ELEM_NARROW;
            sext_q <= 1'b0;
            beat_q <= '0;
            wcnt_q <= '0;
        end else if (flush) begin
            beat_q <= '0;
            wcnt_q <= '0;
        end else begin
            if (accept) begin
                word_q <= in_data;
                mode_q <= elem_mode_e'(elem_mode);
                sext_q <= sign_ext;
                beat_q <= '0;
            end else if (out_fire) begin
                beat_q <= beat_q + 1'b1;
            end
            if (out_fire && last_beat) wcnt_q <= tile_end ? '0 : wcnt_q + 1'b1;
        end
    end

    always_comb begin
        shifted = word_q >> (int'(beat_q) * BEAT_BITS);
        elem    = '0;
        lanes   = '0;
        for (int j = 0; j < LANES; j++) begin
            if (mode_q == ELEM_NATIVE) begin
                lanes[j*DATA_WIDTH +: DATA_WIDTH] = word_q[j*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                elem = shifted[j*ELEM_WIDTH +: ELEM_WIDTH];
                lanes[j*DATA_WIDTH +: DATA_WIDTH] = sext_q ? DATA_WIDTH'($signed(elem))
                                                           : DATA_WIDTH'(elem);
            end
        end
    end

    // Gated so an idle feeder presents zeros (and the skew's lane 0 reads zero after flush).
    assign out_data = out_valid ? lanes : '0;

`ifdef OPERAND_FEEDER_SKEW_EN
    lane_skew #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_skew (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .adv      (out_fire),
        .in_data  (out_data),
        .out_data (out_skew)
    );
`else
    // Unskewed build: the array front end consumes out_data directly.
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: directed cases plus random traffic against a queue-based beat model.
// Skew checks are compiled in when OPERAND_FEEDER_SKEW_EN is defined.
module tb_operand_feeder;

    localparam int BW = 64;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int EW = 8;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rst_n, flush, elem_mode, sign_ext;
    logic [CW-1:0] cfg_words;
    logic          in_valid, in_ready, out_valid, out_ready, out_last, out_tile_last;
    logic [BW-1:0] in_data, out_data;
`ifdef OPERAND_FEEDER_SKEW_EN
    logic [BW-1:0] out_skew;
`endif

    always #5 clk = ~clk;

    operand_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .elem_mode     (elem_mode),
        .sign_ext      (sign_ext),
        .cfg_words     (cfg_words),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_tile_last (out_tile_last)
`ifdef OPERAND_FEEDER_SKEW_EN
        ,
        .out_skew      (out_skew)
`endif
    );

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
        logic          tile;
    } beat_t;

    beat_t         exp_q[$];
    logic [BW-1:0] hist[$];
    int            m_words;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          n_mode, n_sext;
    logic [CW-1:0] n_cfg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] extend(input logic [EW-1:0] e, input logic s);
        logic [DW-1:0] v;
        v = DW'(e);
        if (s && e[EW-1]) v = v | ~DW'({EW{1'b1}});
        return v;
    endfunction

    // Expand an accepted word into its expected beats from the unpacking rules.
    task automatic model_push(input logic [BW-1:0] d, input logic mode, input logic sext);
        int            nb, c;
        beat_t         bt;
        logic [BW-1:0] sh;
        logic [DW-1:0] lane;
        nb = mode ? 1 : BW / (EW * L);
        c  = int'(cfg_words);
        for (int b = 0; b < nb; b++) begin
            bt.data = '0;
            for (int j = 0; j < L; j++) begin
                if (mode) begin
                    sh   = d >> (DW * j);
                    lane = sh[DW-1:0];
                end else begin
                    sh   = d >> (EW * (b * L + j));
                    lane = extend(sh[EW-1:0], sext);
                end
                bt.data = bt.data | (BW'(lane) << (DW * j));
            end
            bt.last = (b == nb - 1);
            bt.tile = 1'b0;
            if (bt.last && c != 0) bt.tile = ((m_words % c) == c - 1);
            exp_q.push_back(bt);
        end
        m_words++;
    endtask

    task automatic model_clear();
        exp_q.delete();
        hist.delete();
        m_words = 0;
    endtask

    // Compare the presented outputs, then advance the model across the coming edge.
    task automatic model_cycle();
        logic          ev, eir;
        beat_t         f;
        logic [BW-1:0] sk_exp, sk_got, sh;
        ev  = (exp_q.size() != 0);
        eir = 1'b1;
        check("out_valid", out_valid, ev);
        if (ev) begin
            f = exp_q[0];
            check("out_data", out_data, f.data);
            check("out_last", out_last, f.last);
            check("out_tile_last", out_tile_last, f.tile);
            eir = out_ready && f.last;
        end
        check("in_ready", in_ready, eir);
`ifdef OPERAND_FEEDER_SKEW_EN
        sk_exp = ev ? (f.data & BW'({DW{1'b1}})) : '0;
        for (int j = 1; j < L; j++) begin
            if (j - 1 < hist.size()) begin
                sh     = hist[j-1] >> (DW * j);
                sk_exp = sk_exp | (BW'(sh[DW-1:0]) << (DW * j));
            end
        end
        sk_got = ev ? out_skew : (out_skew & ~BW'({DW{1'b1}}));
        check("out_skew", sk_got, sk_exp);
`else
        sk_exp = '0;
        sk_got = '0;
        sh     = '0;
`endif
        if (flush) begin
            model_clear();
        end else begin
            if (ev && out_ready) begin
                hist.push_front(f.data);
                if (hist.size() > L - 1) void'(hist.pop_back());
                void'(exp_q.pop_front());
            end
            if (in_valid && eir) model_push(in_data, elem_mode, sign_ext);
        end
    endtask

    task automatic step(input logic iv, input logic [BW-1:0] d, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        elem_mode = n_mode;
        sign_ext  = n_sext;
        cfg_words = n_cfg;
        #1;
        model_cycle();
    endtask

    localparam logic [BW-1:0] W_NAT1   = 64'h0004_0003_0002_0001;
    localparam logic [BW-1:0] W_NAT2   = 64'h0008_0007_0006_0005;
    localparam logic [BW-1:0] W_NAR    = 64'h80FF7F01_04030201;
    localparam logic [BW-1:0] B0_NAR   = 64'h0004_0003_0002_0001;
    localparam logic [BW-1:0] B1_SEXT  = 64'hFF80_FFFF_007F_0001;
    localparam logic [BW-1:0] B1_ZEXT  = 64'h0080_00FF_007F_0001;

    initial begin
        int   sent, hs, tl_cnt, tl_pos;
        logic iv, ordy, fl, prev_fl;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        elem_mode = 1'b0; sign_ext = 1'b0; cfg_words = '0;
        n_mode = 1'b0; n_sext = 1'b0; n_cfg = '0;
        model_clear();
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_tile_last", out_tile_last, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef OPERAND_FEEDER_SKEW_EN
        check("rst_out_skew", out_skew, '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Native streaming, one word per cycle.
        n_mode = 1'b1;
        step(1'b1, W_NAT1, 1'b1, 1'b0);
        step(1'b1, W_NAT2, 1'b1, 1'b0);
        check("nat_beat_w1", out_data, W_NAT1);
        check("nat_last_w1", out_last, 1'b1);
        step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
        check("nat_beat_w2", out_data, W_NAT2);
        check("nat_stream_rdy", in_ready, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("nat_idle", out_valid, 1'b0);

        // Narrow, sign-extended then zero-extended.
        n_mode = 1'b0; n_sext = 1'b1;
        step(1'b1, W_NAR, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("sext_beat0", out_data, B0_NAR);
        check("sext_last0", out_last, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("sext_beat1", out_data, B1_SEXT);
        check("sext_last1", out_last, 1'b1);
        n_sext = 1'b0;
        step(1'b1, W_NAR, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("zext_beat1", out_data, B1_ZEXT);

        // sign_ext toggled after accept must not change the held word.
        n_sext = 1'b1;
        step(1'b1, W_NAR, 1'b1, 1'b0);
        n_sext = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("latched_sext_beat1", out_data, B1_SEXT);

        // Backpressure during beat0 with another word waiting.
        n_sext = 1'b1;
        step(1'b1, W_NAR, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W_NAT2, 1'b0, 1'b0);
            check("bp_hold_data", out_data, B0_NAR);
            check("bp_in_ready", in_ready, 1'b0);
        end
        step(1'b1, W_NAT2, 1'b1, 1'b0);
        step(1'b1, W_NAT2, 1'b1, 1'b0);
        check("bp_beat1", out_data, B1_SEXT);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Tile marking: 3 words per tile, 4 words sent back to back.
        step(1'b0, '0, 1'b0, 1'b1);
        n_cfg = 11'd3;
        sent = 0; hs = 0; tl_cnt = 0; tl_pos = -1;
        for (int i = 0; i < 14; i++) begin
            iv = (sent < 4);
            step(iv, {$urandom, $urandom}, 1'b1, 1'b0);
            if (out_valid && out_ready) begin
                if (out_tile_last) begin
                    tl_cnt++;
                    tl_pos = hs;
                end
                hs++;
            end
            if (iv && in_ready) sent++;
        end
        check("tile_pulses", 64'(tl_cnt), 64'd1);
        check("tile_pos", 64'(tl_pos), 64'd5);
        check("tile_beats", 64'(hs), 64'd8);

        // Flush during beat0 with a word offered, then flush while empty.
        step(1'b1, W_NAR, 1'b1, 1'b0);
        step(1'b1, W_NAT2, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_data", out_data, '0);
`ifdef OPERAND_FEEDER_SKEW_EN
        check("flush_skew", out_skew, '0);
`endif
        step(1'b1, W_NAT2, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_drop", out_valid, 1'b0);

`ifdef OPERAND_FEEDER_SKEW_EN
        // Words with every lane equal to k; view the skew while word 3 is presented.
        n_mode = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b1, {4{16'(k)}}, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("skew_triangle", out_skew, 64'h0000_0001_0002_0003);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        // Asynchronous reset in the middle of a narrow word.
        n_mode = 1'b0;
        step(1'b1, W_NAR, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_data", out_data, '0);
        check("arst_last", out_last, 1'b0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic; cfg_words only changes right after a flush.
        prev_fl = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (prev_fl) n_cfg = CW'($urandom_range(0, 5));
            n_mode = 1'($urandom);
            n_sext = 1'($urandom);
            iv   = ($urandom % 10) < 7;
            ordy = ($urandom % 10) < 7;
            fl   = ($urandom % 50) == 0;
            step(iv, {$urandom, $urandom}, ordy, fl);
            prev_fl = fl;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
